// File: rtl/cell_counter_pkg.sv
// Shared constants and nibble helpers for the cascaded counter chain.
// Used by cnt4_slice and cell_counter_chain.
package cell_counter_pkg;

  localparam int              NIBBLE_W    = 4;
  localparam logic [3:0]      NIBBLE_MAX  = 4'hF;
  localparam int              MAX_NIBBLES = 4;

  // A slice passes carry only when every bit is set.
  function automatic logic nibble_full(input logic [NIBBLE_W-1:0] v);
    return (v == NIBBLE_MAX);
  endfunction

  // Increment wraps naturally modulo 16.
  function automatic logic [NIBBLE_W-1:0] nibble_inc(input logic [NIBBLE_W-1:0] v);
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/cnt4_slice.sv
// One 4-bit loadable up-counter slice with combinational carry-out.
// Load has priority over count; everything is qualified by ce except reset.
module cnt4_slice
  import cell_counter_pkg::*;
#(
  parameter logic [NIBBLE_W-1:0] RST_VAL = '0
) (
  input  logic                clk_24M,
  input  logic                RES,
  input  logic                ce,
  input  logic                load_n,
  input  logic [NIBBLE_W-1:0] d,
  input  logic                en,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] q,
  output logic                cout
);

  logic [NIBBLE_W-1:0] cnt_p0;
  logic [NIBBLE_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt_p0;
    if (ce) begin
      if (!load_n)
        cnt_nxt = d;
      else if (en && cin)
        cnt_nxt = nibble_inc(cnt_p0);
    end
  end

  // Stage p0: slice register
  always_ff @(posedge clk_24M) begin
    if (RES)
      cnt_p0 <= RST_VAL;
    else
      cnt_p0 <= cnt_nxt;
  end

  assign q    = cnt_p0;
  assign cout = cin & nibble_full(cnt_p0);

endmodule

// File: rtl/cell_counter_chain.sv
// Cascaded synchronous up-counter of NIBBLES 4-bit slices, plus reset-release
// flag and carry buffer. Define CARRY_PIPE_EN to register co_buf by one edge.
module cell_counter_chain
  import cell_counter_pkg::*;
#(
  parameter int                     NIBBLES = 2,
  parameter logic [4*NIBBLES-1:0]   RST_VAL = '0
) (
  input  logic                   clk_24M,
  input  logic                   RES,
  input  logic                   ce,
  input  logic                   load_n,
  input  logic [4*NIBBLES-1:0]   d,
  input  logic                   en,
  input  logic                   ci,
  output logic [4*NIBBLES-1:0]   q,
  output logic                   co,
  output logic                   co_buf,
  output logic                   rdy
);

  logic [NIBBLES:0] carry;
  logic             rdy_p0;

  assign carry[0] = ci;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_slice
    cnt4_slice #(
      .RST_VAL (RST_VAL[k*NIBBLE_W +: NIBBLE_W])
    ) u_slice (
      .clk_24M (clk_24M),
      .RES     (RES),
      .ce      (ce),
      .load_n  (load_n),
      .d       (d[k*NIBBLE_W +: NIBBLE_W]),
      .en      (en),
      .cin     (carry[k]),
      .q       (q[k*NIBBLE_W +: NIBBLE_W]),
      .cout    (carry[k+1])
    );
  end

  // Ripple carry out of the top slice already includes ci and all-ones.
  assign co = carry[NIBBLES];

  // Stage p0: reset-release flag, D tied high, deliberately ignores ce
  always_ff @(posedge clk_24M) begin
    if (RES)
      rdy_p0 <= 1'b0;
    else
      rdy_p0 <= 1'b1;
  end

  assign rdy = rdy_p0;

`ifdef CARRY_PIPE_EN
  logic co_buf_p1;

  // Stage p1: carry buffer, free-running regardless of ce
  always_ff @(posedge clk_24M) begin
    if (RES)
      co_buf_p1 <= 1'b0;
    else
      co_buf_p1 <= co;
  end

  assign co_buf = co_buf_p1;
`else
  assign co_buf = co;
`endif

endmodule

// File: tb/tb_cell_counter_chain.sv
// Scoreboard bench for cell_counter_chain (NIBBLES=2): driver queues expected
// results, a negedge monitor pops and compares them.
module tb_cell_counter_chain;

  logic       clk_24M = 1'b0;
  logic       RES;
  logic       ce;
  logic       load_n;
  logic [7:0] d;
  logic       en;
  logic       ci;
  logic [7:0] q;
  logic       co;
  logic       co_buf;
  logic       rdy;

  typedef struct {
    logic [7:0] q;
    logic       co;
    logic       cob;
    logic       rdy;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [7:0] prev_q = 8'h00;

  always #5 clk_24M = ~clk_24M;

  cell_counter_chain #(
    .NIBBLES (2),
    .RST_VAL (8'h00)
  ) dut (
    .clk_24M (clk_24M),
    .RES     (RES),
    .ce      (ce),
    .load_n  (load_n),
    .d       (d),
    .en      (en),
    .ci      (ci),
    .q       (q),
    .co      (co),
    .co_buf  (co_buf),
    .rdy     (rdy)
  );

  // Apply inputs, clock one edge, queue the hand-computed post-edge result.
  task automatic step(input logic r, input logic c, input logic ln,
                      input logic [7:0] dv, input logic e, input logic cin,
                      input logic [7:0] eq, input logic eco, input logic erdy,
                      input string nm);
    exp_t x;
    logic pre_co;
    RES = r; ce = c; load_n = ln; d = dv; en = e; ci = cin;
    pre_co = cin & (prev_q == 8'hFF);
    @(posedge clk_24M);
    #1;
    x.q = eq; x.co = eco; x.rdy = erdy; x.name = nm;
`ifdef CARRY_PIPE_EN
    x.cob = r ? 1'b0 : pre_co;
`else
    x.cob = eco;
`endif
    exp_q.push_back(x);
    prev_q = eq;
    @(negedge clk_24M);
    #1;
  endtask

  always @(negedge clk_24M) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      n_cmp++;
      if (q !== x.q) begin
        n_fail++;
        $display("FAIL %s.q actual=%h required=%h", x.name, q, x.q);
      end
      n_cmp++;
      if (co !== x.co) begin
        n_fail++;
        $display("FAIL %s.co actual=%b required=%b", x.name, co, x.co);
      end
      n_cmp++;
      if (co_buf !== x.cob) begin
        n_fail++;
        $display("FAIL %s.co_buf actual=%b required=%b", x.name, co_buf, x.cob);
      end
      n_cmp++;
      if (rdy !== x.rdy) begin
        n_fail++;
        $display("FAIL %s.rdy actual=%b required=%b", x.name, rdy, x.rdy);
      end
    end
  end

  initial begin
    RES = 1'b1; ce = 1'b0; load_n = 1'b1; d = 8'h00; en = 1'b0; ci = 1'b0;
    @(negedge clk_24M);
    #1;

    //   RES ce ln  d      en ci   q      co   rdy  name
    step(1, 1, 1, 8'h00, 0, 0, 8'h00, 0, 0, "reset0");
    step(1, 1, 0, 8'h55, 1, 1, 8'h00, 0, 0, "reset1");
    step(0, 1, 1, 8'h00, 0, 0, 8'h00, 0, 1, "rdy_set");

    step(0, 1, 0, 8'h3E, 1, 1, 8'h3E, 0, 1, "load_3E");
    step(0, 1, 1, 8'h00, 1, 1, 8'h3F, 0, 1, "cnt_3F");
    step(0, 1, 1, 8'h00, 1, 1, 8'h40, 0, 1, "ripple_40");
    step(0, 1, 1, 8'h00, 1, 1, 8'h41, 0, 1, "cnt_41");

    step(0, 1, 0, 8'hFE, 1, 1, 8'hFE, 0, 1, "load_FE");
    step(0, 1, 1, 8'h00, 1, 1, 8'hFF, 1, 1, "cnt_FF");
    step(0, 0, 1, 8'h00, 1, 1, 8'hFF, 1, 1, "ce0_at_FF");
    step(0, 1, 1, 8'h00, 0, 1, 8'hFF, 1, 1, "en0_at_FF");
    step(0, 1, 1, 8'h00, 1, 1, 8'h00, 0, 1, "wrap_00");
    step(0, 1, 1, 8'h00, 1, 1, 8'h01, 0, 1, "after_wrap");

    step(0, 1, 0, 8'hFF, 1, 0, 8'hFF, 0, 1, "load_FF_ci0");
    step(0, 1, 1, 8'h00, 1, 0, 8'hFF, 0, 1, "ci0_hold_FF");

    step(0, 1, 0, 8'h10, 0, 0, 8'h10, 0, 1, "load_10");
    step(0, 0, 0, 8'h55, 1, 1, 8'h10, 0, 1, "ce0_hold_a");
    step(0, 0, 0, 8'h55, 1, 1, 8'h10, 0, 1, "ce0_hold_b");
    step(0, 0, 1, 8'h55, 1, 1, 8'h10, 0, 1, "ce0_hold_c");
    step(0, 1, 1, 8'h00, 1, 0, 8'h10, 0, 1, "ci0_hold");
    step(0, 1, 1, 8'h00, 0, 1, 8'h10, 0, 1, "en0_hold");

    step(0, 1, 0, 8'h78, 1, 1, 8'h78, 0, 1, "load_78");
    step(0, 1, 1, 8'h00, 1, 1, 8'h79, 0, 1, "cnt_79");
    step(0, 1, 1, 8'h00, 1, 1, 8'h7A, 0, 1, "cnt_7A");
    step(1, 1, 0, 8'h33, 1, 1, 8'h00, 0, 0, "mid_reset");
    step(0, 1, 1, 8'h00, 1, 1, 8'h01, 0, 1, "resume_01");
    step(0, 1, 1, 8'h00, 1, 1, 8'h02, 0, 1, "resume_02");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk_24M);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
